// File: rtl/alt_vipitc130_mode_sched_pkg.sv
// Shared types and constants for the clocked-video-output mode scheduler.
package alt_vipitc130_mode_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEARCH     = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_COMMIT     = 2'd3
  } sched_state_e;

  localparam int COUNT_W = 16;

endpackage

// File: rtl/alt_vipitc130_common_to_binary.sv
// One-hot mode select to 1-based binary index; all-zero input yields 0.
module alt_vipitc130_common_to_binary #(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2
) (
  input  logic [NO_OF_MODES-1:0]      one_hot,
  output logic [LOG2_NO_OF_MODES-1:0] binary
);

  always_comb begin
    binary = '0;
    for (int i = 0; i < NO_OF_MODES; i++) begin
      if (one_hot[i]) binary = binary | LOG2_NO_OF_MODES'(i + 1);
    end
  end

endmodule

// File: rtl/alt_vipitc130_common_mode_scheduler.sv
// Mode-bank scheduler: explicit or round-robin mode switches deferred to frame boundaries.
// Define ALT_VIPITC130_MODE_SCHED_COUNT_EN to add the saturating switch_count output.
//
// state       | meaning
// ST_IDLE     | accepting requests, watching the active mode's valid bit
// ST_SEARCH   | round-robin scan, one bank entry per cycle
// ST_WAIT_FRAME | target chosen, waiting for frame_end (or none active)
// ST_COMMIT   | drive the new select and pulse mode_change
module alt_vipitc130_common_mode_scheduler
  import alt_vipitc130_mode_sched_pkg::*;
#(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NO_OF_MODES-1:0]      mode_valid,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [LOG2_NO_OF_MODES-1:0] req_mode,
  input  logic                        next_mode,
  input  logic                        frame_end,
  output logic [NO_OF_MODES-1:0]      mode_one_hot,
  output logic [LOG2_NO_OF_MODES-1:0] mode_binary,
  output logic                        mode_change,
  output logic                        req_err,
`ifdef ALT_VIPITC130_MODE_SCHED_COUNT_EN
  output logic [COUNT_W-1:0]          switch_count,
`endif
  output logic                        busy
);

  localparam int VEXT_W = 1 << LOG2_NO_OF_MODES;
  localparam int MISS_W = $clog2(NO_OF_MODES + 1);
  localparam logic [LOG2_NO_OF_MODES-1:0] LAST_IDX  = LOG2_NO_OF_MODES'(NO_OF_MODES - 1);
  localparam logic [MISS_W-1:0]           LAST_MISS = MISS_W'(NO_OF_MODES - 1);

  sched_state_e                state_q, state_d;
  logic [NO_OF_MODES-1:0]      one_hot_q, one_hot_d;
  logic                        active_q, active_d;
  logic [LOG2_NO_OF_MODES-1:0] cur_q, cur_d;
  logic [LOG2_NO_OF_MODES-1:0] target_q, target_d;
  logic [LOG2_NO_OF_MODES-1:0] ptr_q, ptr_d;
  logic [MISS_W-1:0]           miss_q, miss_d;
  logic                        change_q, change_d;
  logic                        err_q, err_d;

  // Zero-padded so any index the binary field can hold reads as invalid beyond the bank.
  logic [VEXT_W-1:0] valid_ext;
  assign valid_ext = VEXT_W'(mode_valid);

  function automatic logic [LOG2_NO_OF_MODES-1:0] wrap_inc(input logic [LOG2_NO_OF_MODES-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    one_hot_d = one_hot_q;
    active_d  = active_q;
    cur_d     = cur_q;
    target_d  = target_q;
    ptr_d     = ptr_q;
    miss_d    = miss_q;
    change_d  = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (active_q && !valid_ext[cur_q]) begin
          one_hot_d = '0;
          active_d  = 1'b0;
          change_d  = 1'b1;
          ptr_d     = wrap_inc(cur_q);
          miss_d    = '0;
          state_d   = ST_SEARCH;
        end else if (req_valid) begin
          if (req_mode > LAST_IDX || !valid_ext[req_mode]) begin
            err_d = 1'b1;
          end else begin
            target_d = req_mode;
            state_d  = ST_WAIT_FRAME;
          end
        end else if (next_mode) begin
          ptr_d   = active_q ? wrap_inc(cur_q) : '0;
          miss_d  = '0;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (valid_ext[ptr_q]) begin
          target_d = ptr_q;
          state_d  = ST_WAIT_FRAME;
        end else if (miss_q == LAST_MISS) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ptr_d  = wrap_inc(ptr_q);
          miss_d = miss_q + 1'b1;
        end
      end
      ST_WAIT_FRAME: begin
        // A target that vanished aborts even if the frame boundary is here.
        if (!valid_ext[target_q]) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (!active_q || frame_end) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        one_hot_d = {{(NO_OF_MODES-1){1'b0}}, 1'b1} << target_q;
        cur_d     = target_q;
        active_d  = 1'b1;
        change_d  = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      one_hot_q <= '0;
      active_q  <= 1'b0;
      cur_q     <= '0;
      target_q  <= '0;
      ptr_q     <= '0;
      miss_q    <= '0;
      change_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      one_hot_q <= one_hot_d;
      active_q  <= active_d;
      cur_q     <= cur_d;
      target_q  <= target_d;
      ptr_q     <= ptr_d;
      miss_q    <= miss_d;
      change_q  <= change_d;
      err_q     <= err_d;
    end
  end

`ifdef ALT_VIPITC130_MODE_SCHED_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (change_d && count_q != {COUNT_W{1'b1}}) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign switch_count = count_q;
`endif

  alt_vipitc130_common_to_binary #(
    .NO_OF_MODES      (NO_OF_MODES),
    .LOG2_NO_OF_MODES (LOG2_NO_OF_MODES)
  ) u_to_binary (
    .one_hot (one_hot_q),
    .binary  (mode_binary)
  );

  assign mode_one_hot = one_hot_q;
  assign mode_change  = change_q;
  assign req_err      = err_q;
  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);

endmodule
